scalar_decode_stage: RTL and testbench
======================================

# scalar_decode_stage

Registered, back-pressured decode stage for the scalar pipe, placed between instruction queue 0 and the scalar register-file/ALU issue point. It classifies each 32-bit instruction by its opcode (bits [31:26]) into immediate-ALU, register-ALU or control classes. It extracts register addresses and a sign-extended immediate, and presents the result through a one-entry output register with valid/ready handshakes on both sides. An optional scoreboard stalls issue on read-after-write and write-after-write hazards against in-flight writes.

## Interface
- `DATA_WIDTH`, 32: width of the extended immediate.
- `INSTR_WIDTH`, 32: instruction width. Must be ≥ 32.
- `REG_ADDR_W`, 4: register address width. Register count is 2^REG_ADDR_W.
- `IMM_WIDTH`, 18: immediate field width in bits [IMM_WIDTH-1:0]. Requires IMM_WIDTH ≤ DATA_WIDTH.
- `clk  in  1`: clock.
- `rst  in  1`: reset, asynchronous, active-high.
- `in_valid  in  1`: instruction available.
- `in_ready  out  1`: stage accepts the instruction this cycle.
- `in_instr  in  INSTR_WIDTH`: instruction word.
- `flush  in  1`: discard the held decode result.
- `out_valid  out  1`: decoded bundle valid.
- `out_ready  in  1`: consumer accepts the bundle.
- `out_op  out  op_t`: opcode.
- `out_rs1`, `out_rs2`, `out_rd  out  REG_ADDR_W each`: source and destination addresses.
- `out_we  out  1`: register write enable.
- `out_imm  out  DATA_WIDTH`: sign-extended immediate.
- `out_use_imm  out  1`: ALU B-operand select.
- `out_illegal  out  1`: opcode not recognised.
- `illegal_seen  out  1`: sticky flag, set on any accepted illegal instruction.
- `wb_valid  in  1`, `wb_rd  in  REG_ADDR_W`: writeback retire, used to clear the scoreboard.

## Operation
- Decode classes:
  - Immediate ALU (`ADD_IMM`, `SUB_IMM`, `SHL_IMM`, `SHR_IMM`, `CMP_IMM`, `MOV_IMM`, `LCSET_IMM`): rs1 and rd from the SI fields; imm sign-extended; use_imm=1; we=1 except for CMP/LCSET.
  - Register ALU (`*_REG` counterparts): rs1, rs2 and rd from the SR fields; use_imm=0; we=1 except for CMP/LCSET.
  - Control (`BRANCH`, `LOOP`, `HALT`, `YIELD`, `NOP`): rs1 and imm from the C fields; use_imm=1; we=0.
  - Any other opcode: illegal=1; all address, imm, use_imm and we fields 0.
- Unused fields are driven to 0, never X.
- Accept: `in_valid && in_ready`. On accept, the output register loads the decoded bundle and out_valid is set.
- Issue: `out_valid && out_ready`. Issue with no simultaneous accept clears out_valid.
- `in_ready = (!out_valid || out_ready) && !hazard`, with hazard defined under Configuration.
- Flush: clears out_valid next cycle and forces in_ready=0 during the flush cycle. Scoreboard state is unchanged.
- illegal_seen: set on accept of an illegal instruction; cleared only by rst.

## Timing
- Latency: accept in cycle N gives out_valid in cycle N+1.
- Throughput: one instruction per cycle when out_ready is held high and there is no hazard.
- Output-register contents are stable while `out_valid && !out_ready`.
- in_ready is combinational from out_ready, in_instr and scoreboard state. It has no path from in_valid.
- Reset values:
  - out_valid=0, illegal_seen=0.
  - All out_* data fields 0, with out_op = the value of opcode field 0.
  - Scoreboard all clear.
- Reset asserted mid-operation drops the held bundle immediately; there is no issue.

## Configuration
- Macro: `QTPA_DECODE_SCOREBOARD_EN`.
- Defined:
  - A busy bit per register.
  - Set on issue with out_we=1 for out_rd.
  - Cleared by `wb_valid` for wb_rd.
  - Simultaneous set and clear of the same register: set wins.
  - hazard = in_valid and the incoming instruction reads a busy rs1/rs2 or writes a busy rd. Only fields actually used by the class are checked.
  - The bundle in the output register counts as in-flight: if it writes rd, an incoming read or write of rd is a hazard.
  - A wb_valid in the same cycle as the hazard check is not forwarded; it takes effect next cycle.
- Undefined: hazard=0; wb_valid and wb_rd are ignored.

## Structure
- `qtpa_pkg` holds:
  - `op_t` and the instruction format structs, parametrised by the field widths above.
  - A new `decoded_t` struct for the output bundle.
  - A new `op_class_t` enum: `CLS_IMM`, `CLS_REG`, `CLS_CTRL`, `CLS_ILL`.
- Sub-module `scalar_decode_comb`: a purely combinational instruction-to-`decoded_t` decoder, instantiated once. The stage owns the handshake, the flush, illegal_seen and the scoreboard.

## Test plan
- Reset, then stream `ADD_IMM` rd=3 rs1=2 imm=0x3FFFF with out_ready=1 → next cycle out_imm=0xFFFFFFFF, use_imm=1, we=1, rd=3.
- Back-pressure: out_ready=0 for 3 cycles while in_valid=1 → in_ready=0, out_* unchanged; release → one bundle per cycle, no loss or duplication.
- Opcode 6'h3F → out_illegal=1, all other fields 0, illegal_seen=1 until rst.
- Flush with a bundle held → out_valid=0 next cycle; that bundle is never issued.
- Scoreboard on: issue `ADD_REG` rd=5, then `SUB_REG` rs2=5 → in_ready=0 until wb_valid with wb_rd=5, accepted the following cycle.
- Scoreboard on: wb_valid for rd=5 in the same cycle as a new issue writing rd=5 → busy[5] stays set. Assert rst mid-stall → all busy bits clear and out_valid=0.

Source files
------------

// File: rtl/qtpa_pkg.sv
// qtpa_pkg: shared opcode, instruction-format and decode-bundle types for the
// scalar decode stage. Field widths below are the build-wide layout; the stage
// parameters default to them and are checked against them at elaboration.
//
// Instruction layouts (opcode always in [31:26], fields packed below it):
//   SI : op | rd | rs1 | imm[IMM_W-1:0]
//   SR : op | rd | rs1 | rs2 | reserved
//   C  : op | reserved | rs1 | imm[IMM_W-1:0]
package qtpa_pkg;

   localparam int QTPA_DATA_W     = 32;
   localparam int QTPA_INSTR_W    = 32;
   localparam int QTPA_REG_ADDR_W = 4;
   localparam int QTPA_IMM_W      = 18;
   localparam int QTPA_OP_W       = 6;
   localparam int QTPA_SR_PAD_W   = 32 - QTPA_OP_W - 3*QTPA_REG_ADDR_W;

   // Opcode space. Register-ALU ops sit 0x10 above their immediate twins.
   // Encoding 0 is NOP so a cleared bundle reads as a harmless control op.
   typedef enum logic [QTPA_OP_W-1:0] {
      NOP       = 6'h00,
      ADD_IMM   = 6'h01,
      SUB_IMM   = 6'h02,
      SHL_IMM   = 6'h03,
      SHR_IMM   = 6'h04,
      CMP_IMM   = 6'h05,
      MOV_IMM   = 6'h06,
      LCSET_IMM = 6'h07,
      ADD_REG   = 6'h11,
      SUB_REG   = 6'h12,
      SHL_REG   = 6'h13,
      SHR_REG   = 6'h14,
      CMP_REG   = 6'h15,
      MOV_REG   = 6'h16,
      LCSET_REG = 6'h17,
      BRANCH    = 6'h20,
      LOOP      = 6'h21,
      HALT      = 6'h22,
      YIELD     = 6'h23
   } op_t;

   typedef enum logic [1:0] {
      CLS_IMM,
      CLS_REG,
      CLS_CTRL,
      CLS_ILL
   } op_class_t;

   typedef struct packed {
      logic [QTPA_OP_W-1:0]       op;
      logic [QTPA_REG_ADDR_W-1:0] rd;
      logic [QTPA_REG_ADDR_W-1:0] rs1;
      logic [QTPA_IMM_W-1:0]      imm;
   } si_fmt_t;

   typedef struct packed {
      logic [QTPA_OP_W-1:0]       op;
      logic [QTPA_REG_ADDR_W-1:0] rd;
      logic [QTPA_REG_ADDR_W-1:0] rs1;
      logic [QTPA_REG_ADDR_W-1:0] rs2;
      logic [QTPA_SR_PAD_W-1:0]   rsvd;
   } sr_fmt_t;

   typedef struct packed {
      logic [QTPA_OP_W-1:0]       op;
      logic [QTPA_REG_ADDR_W-1:0] rsvd;
      logic [QTPA_REG_ADDR_W-1:0] rs1;
      logic [QTPA_IMM_W-1:0]      imm;
   } c_fmt_t;

   // Bundle presented to the issue point.
   typedef struct packed {
      op_t                        op;
      logic [QTPA_REG_ADDR_W-1:0] rs1;
      logic [QTPA_REG_ADDR_W-1:0] rs2;
      logic [QTPA_REG_ADDR_W-1:0] rd;
      logic                       we;
      logic [QTPA_DATA_W-1:0]     imm;
      logic                       use_imm;
      logic                       illegal;
   } decoded_t;

   function automatic op_class_t op_class(input logic [QTPA_OP_W-1:0] opc);
      case (opc)
         ADD_IMM, SUB_IMM, SHL_IMM, SHR_IMM, CMP_IMM, MOV_IMM, LCSET_IMM:
            return CLS_IMM;
         ADD_REG, SUB_REG, SHL_REG, SHR_REG, CMP_REG, MOV_REG, LCSET_REG:
            return CLS_REG;
         BRANCH, LOOP, HALT, YIELD, NOP:
            return CLS_CTRL;
         default:
            return CLS_ILL;
      endcase
   endfunction

   // ALU ops write rd except compares and loop-count sets.
   function automatic logic op_writes(input logic [QTPA_OP_W-1:0] opc);
      return !(opc == CMP_IMM || opc == LCSET_IMM ||
               opc == CMP_REG || opc == LCSET_REG);
   endfunction

   function automatic logic [QTPA_DATA_W-1:0] sign_extend(input logic [QTPA_IMM_W-1:0] v);
      return QTPA_DATA_W'($signed(v));
   endfunction

endpackage

// File: rtl/scalar_decode_comb.sv
// scalar_decode_comb: purely combinational instruction -> decoded_t decoder.
// Unused fields of each class are driven to zero; an unrecognised opcode
// yields an all-zero bundle with only the illegal flag set.
module scalar_decode_comb
   import qtpa_pkg::*;
#(
   parameter int INSTR_WIDTH = QTPA_INSTR_W
) (
   input  logic [INSTR_WIDTH-1:0] instr,
   output decoded_t               dec
);

   si_fmt_t              si;
   sr_fmt_t              sr;
   c_fmt_t               cf;
   logic [QTPA_OP_W-1:0] opc;

   // All formats live in the low 32 bits; wider words carry sideband above.
   assign si  = si_fmt_t'(instr[31:0]);
   assign sr  = sr_fmt_t'(instr[31:0]);
   assign cf  = c_fmt_t'(instr[31:0]);
   assign opc = si.op;

   // Class-directed field extraction with zero defaults
   always_comb begin
      dec = '0;
      case (op_class(opc))
         CLS_IMM: begin
            dec.op      = op_t'(opc);
            dec.rd      = si.rd;
            dec.rs1     = si.rs1;
            dec.imm     = sign_extend(si.imm);
            dec.use_imm = 1'b1;
            dec.we      = op_writes(opc);
         end
         CLS_REG: begin
            dec.op      = op_t'(opc);
            dec.rd      = sr.rd;
            dec.rs1     = sr.rs1;
            dec.rs2     = sr.rs2;
            dec.we      = op_writes(opc);
         end
         CLS_CTRL: begin
            dec.op      = op_t'(opc);
            dec.rs1     = cf.rs1;
            dec.imm     = sign_extend(cf.imm);
            dec.use_imm = 1'b1;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
   end

   // Format views overlap; the duplicated opcode copies and reserved bits
   // are deliberately ignored.
   logic unused_fields;
   assign unused_fields = ^{sr.op, sr.rsvd, cf.op, cf.rsvd};

   if (INSTR_WIDTH > 32) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^instr[INSTR_WIDTH-1:32];
   end

endmodule

// File: rtl/scalar_decode_stage.sv
// scalar_decode_stage: registered, back-pressured decode stage between
// instruction queue 0 and the scalar issue point. One-entry output register
// with valid/ready on both sides, flush, sticky illegal flag.
// Optional read/write hazard scoreboard: define QTPA_DECODE_SCOREBOARD_EN.
module scalar_decode_stage
   import qtpa_pkg::*;
#(
   parameter int DATA_WIDTH  = QTPA_DATA_W,
   parameter int INSTR_WIDTH = QTPA_INSTR_W,
   parameter int REG_ADDR_W  = QTPA_REG_ADDR_W,
   parameter int IMM_WIDTH   = QTPA_IMM_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INSTR_WIDTH-1:0] in_instr,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output op_t                    out_op,
   output logic [REG_ADDR_W-1:0]  out_rs1,
   output logic [REG_ADDR_W-1:0]  out_rs2,
   output logic [REG_ADDR_W-1:0]  out_rd,
   output logic                   out_we,
   output logic [DATA_WIDTH-1:0]  out_imm,
   output logic                   out_use_imm,
   output logic                   out_illegal,
   output logic                   illegal_seen,
   input  logic                   wb_valid,
   input  logic [REG_ADDR_W-1:0]  wb_rd
);

   // The decoded_t layout is fixed by the package; reject a mismatched build.
   if (DATA_WIDTH != QTPA_DATA_W || REG_ADDR_W != QTPA_REG_ADDR_W ||
       IMM_WIDTH != QTPA_IMM_W || INSTR_WIDTH < 32 || IMM_WIDTH > DATA_WIDTH) begin : g_cfg_bad
      $error("scalar_decode_stage: parameters do not match qtpa_pkg field layout");
   end

   localparam int NUM_REGS = 1 << REG_ADDR_W;

   decoded_t dec;
   decoded_t held;
   logic     hazard;
   logic     accept;
   logic     issue;

   scalar_decode_comb #(
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_decode (
      .instr (in_instr),
      .dec   (dec)
   );

   // hazard is evaluated without in_valid so in_ready never depends on it;
   // accept still requires in_valid, which gives the same handshake.
   assign in_ready = (!out_valid || out_ready) && !flush && !hazard;
   assign accept   = in_valid && in_ready;
   // A flushed bundle is never issued, even if out_ready is high.
   assign issue    = out_valid && out_ready && !flush;

   // Output register: load on accept, drop on issue or flush, hold otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         held      <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         held      <= dec;
      end else if (issue || flush) begin
         out_valid <= 1'b0;
      end
   end

   // Sticky record of any accepted illegal instruction
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         illegal_seen <= 1'b0;
      else if (accept && dec.illegal)
         illegal_seen <= 1'b1;
   end

   assign out_op      = held.op;
   assign out_rs1     = held.rs1;
   assign out_rs2     = held.rs2;
   assign out_rd      = held.rd;
   assign out_we      = held.we;
   assign out_imm     = held.imm;
   assign out_use_imm = held.use_imm;
   assign out_illegal = held.illegal;

`ifdef QTPA_DECODE_SCOREBOARD_EN
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;
   logic [NUM_REGS-1:0] pending;
   logic                chk_rs1;
   logic                chk_rs2;

   // Outstanding writes: retired-pending scoreboard plus the held bundle
   always_comb begin
      pending = busy;
      if (out_valid && held.we)
         pending[held.rd] = 1'b1;
   end

   // Only fields the incoming class really uses take part in the check.
   assign chk_rs1 = !dec.illegal;
   assign chk_rs2 = (op_class(dec.op) == CLS_REG);

   assign hazard = (chk_rs1 && pending[dec.rs1]) ||
                   (chk_rs2 && pending[dec.rs2]) ||
                   (dec.we  && pending[dec.rd]);

   // Writeback clears first, issue sets after, so a same-register collision
   // leaves the bit set; writeback is seen by the hazard check one cycle later.
   always_comb begin
      busy_nxt = busy;
      if (wb_valid)
         busy_nxt[wb_rd] = 1'b0;
      if (issue && held.we)
         busy_nxt[held.rd] = 1'b1;
   end

   // Scoreboard state; unaffected by flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy <= '0;
      else
         busy <= busy_nxt;
   end
`else
   assign hazard = 1'b0;

   logic unused_wb;
   assign unused_wb = ^{wb_valid, wb_rd, NUM_REGS[0]};
`endif

endmodule

// File: tb/tb_scalar_decode_stage.sv
// tb_scalar_decode_stage: directed plus randomized checks of scalar_decode_stage
// against a queue-based behavioural model of the decode stage.
module tb_scalar_decode_stage;

   typedef struct packed {
      logic [5:0]  op;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic [3:0]  rd;
      logic        we;
      logic [31:0] imm;
      logic        use_imm;
      logic        illegal;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   qtpa_pkg::op_t     out_op;
   logic [3:0]        out_rs1;
   logic [3:0]        out_rs2;
   logic [3:0]        out_rd;
   logic              out_we;
   logic [31:0]       out_imm;
   logic              out_use_imm;
   logic              out_illegal;
   logic              illegal_seen;
   logic              wb_valid;
   logic [3:0]        wb_rd;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];
   bit   m_seen;
   bit   [15:0] m_busy;
   logic obs_rdy;

   scalar_decode_stage dut (
      .clk (clk), .rst (rst),
      .in_valid (in_valid), .in_ready (in_ready), .in_instr (in_instr),
      .flush (flush),
      .out_valid (out_valid), .out_ready (out_ready), .out_op (out_op),
      .out_rs1 (out_rs1), .out_rs2 (out_rs2), .out_rd (out_rd),
      .out_we (out_we), .out_imm (out_imm), .out_use_imm (out_use_imm),
      .out_illegal (out_illegal), .illegal_seen (illegal_seen),
      .wb_valid (wb_valid), .wb_rd (wb_rd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t obs_bundle();
      exp_t o;
      o.op = out_op; o.rs1 = out_rs1; o.rs2 = out_rs2; o.rd = out_rd;
      o.we = out_we; o.imm = out_imm; o.use_imm = out_use_imm; o.illegal = out_illegal;
      return o;
   endfunction

   // Reference decode straight from the opcode table and field positions.
   function automatic exp_t model_decode(input logic [31:0] w);
      exp_t   e   = '0;
      int     opc = int'(w[31:26]);
      longint iv  = longint'(w[17:0]);
      if (iv >= 131072) iv = iv - 262144;
      if ((opc >= 1 && opc <= 7) || (opc >= 17 && opc <= 23)) begin
         e.op  = w[31:26];
         e.rd  = w[25:22];
         e.rs1 = w[21:18];
         e.we  = (opc % 16 != 5) && (opc % 16 != 7);
         if (opc <= 7) begin
            e.imm = iv[31:0];
            e.use_imm = 1'b1;
         end else begin
            e.rs2 = w[17:14];
         end
      end else if (opc == 0 || (opc >= 32 && opc <= 35)) begin
         e.op = w[31:26];
         e.rs1 = w[21:18];
         e.imm = iv[31:0];
         e.use_imm = 1'b1;
      end else begin
         e.illegal = 1'b1;
      end
      return e;
   endfunction

   function automatic bit model_hazard(input exp_t e);
      bit haz = 1'b0;
`ifdef QTPA_DECODE_SCOREBOARD_EN
      bit [15:0] pend = m_busy;
      if (q.size() != 0 && q[0].we) pend[q[0].rd] = 1'b1;
      if (!e.illegal && pend[e.rs1]) haz = 1'b1;
      if (!e.illegal && e.op >= 6'h11 && e.op <= 6'h17 && pend[e.rs2]) haz = 1'b1;
      if (e.we && pend[e.rd]) haz = 1'b1;
`else
      if (e.illegal && !e.illegal) haz = 1'b1;
`endif
      return haz;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0]  legal [19] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                  6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17,
                                  6'h20, 6'h21, 6'h22, 6'h23};
      logic [5:0]  bad [6]    = '{6'h08, 6'h10, 6'h18, 6'h1F, 6'h24, 6'h3F};
      logic [31:0] w          = $urandom;
      if ($urandom_range(0, 9) == 0) w[31:26] = bad[$urandom_range(0, 5)];
      else                           w[31:26] = legal[$urandom_range(0, 18)];
      w[25:22] = 4'($urandom_range(0, 3));
      w[21:18] = 4'($urandom_range(0, 3));
      w[17:14] = 4'($urandom_range(0, 3));
      return w;
   endfunction

   // One clock: check settled outputs, drive inputs, check in_ready, advance model.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy,
                        input logic fl = 1'b0, input logic wv = 1'b0,
                        input logic [3:0] wr = 4'd0);
      exp_t e;
      bit   haz, rdy, acc, iss;
      chk("out_valid", out_valid, q.size() != 0);
      chk("illegal_seen", illegal_seen, m_seen);
      if (q.size() != 0) chk("bundle", {11'b0, obs_bundle()}, {11'b0, q[0]});
      in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
      wb_valid = wv; wb_rd = wr;
      #1;
      e   = model_decode(ins);
      haz = model_hazard(e);
      rdy = (q.size() == 0 || ordy) && !fl && !haz;
      obs_rdy = in_ready;
      if (v || !haz) chk("in_ready", in_ready, rdy);
      acc = v && rdy;
      iss = (q.size() != 0) && ordy && !fl;
      @(posedge clk);
`ifdef QTPA_DECODE_SCOREBOARD_EN
      if (wv) m_busy[wr] = 1'b0;
      if (iss && q[0].we) m_busy[q[0].rd] = 1'b1;
`endif
      if (q.size() != 0 && (iss || fl)) void'(q.pop_front());
      if (acc) begin
         q.push_back(e);
         if (e.illegal) m_seen = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input bit mid);
      rst = 1'b1;
      in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0;
      #2;
      if (mid) chk("rst_drop", out_valid, 1'b0);
      @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_illegal_seen", illegal_seen, 1'b0);
      chk("rst_bundle", {11'b0, obs_bundle()}, 64'd0);
      q.delete();
      m_seen = 1'b0;
      m_busy = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      exp_t o;
      in_instr = '0; out_ready = 1'b0; wb_rd = '0;
      do_reset(1'b0);

      // ADD_IMM rd=3 rs1=2 imm=0x3FFFF
      cycle(1'b1, {6'h01, 4'd3, 4'd2, 18'h3FFFF}, 1'b1);
      chk("addi_imm", out_imm, 32'hFFFF_FFFF);
      chk("addi_use_imm", out_use_imm, 1'b1);
      chk("addi_we", out_we, 1'b1);
      chk("addi_rd", out_rd, 4'd3);

      // back-pressure: consumer stalls three cycles, then drains
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, {6'h01, 4'd8, 4'd9, 18'h00123}, 1'b0);
         chk("bp_ready", obs_rdy, 1'b0);
      end
      cycle(1'b1, {6'h01, 4'd8, 4'd9, 18'h00123}, 1'b1);
      cycle(1'b1, {6'h12, 4'd10, 4'd11, 4'd12, 14'h2AAA}, 1'b1);
      cycle(1'b1, {6'h05, 4'd0, 4'd13, 18'h20000}, 1'b1);
      cycle(1'b0, 32'd0, 1'b1);
      cycle(1'b0, 32'd0, 1'b1);
      chk("bp_drained", out_valid, 1'b0);

      // illegal opcode
      cycle(1'b1, {6'h3F, 26'h3FF_FFFF}, 1'b1);
      chk("ill_flag", out_illegal, 1'b1);
      o = obs_bundle();
      o.illegal = 1'b0;
      chk("ill_fields", {11'b0, o}, 64'd0);
      chk("ill_seen", illegal_seen, 1'b1);
      cycle(1'b1, {6'h20, 4'd0, 4'd1, 18'h00040}, 1'b1);
      cycle(1'b0, 32'd0, 1'b1);
      chk("ill_sticky", illegal_seen, 1'b1);

      // flush a held bundle while the consumer is also ready
      cycle(1'b1, {6'h21, 4'd0, 4'd1, 18'h3FFF0}, 1'b0);
      cycle(1'b1, {6'h22, 4'd0, 4'd1, 18'h00000}, 1'b1, 1'b1);
      chk("flush_ready", obs_rdy, 1'b0);
      chk("flush_valid", out_valid, 1'b0);
      cycle(1'b0, 32'd0, 1'b1);

      // reset with a held bundle
      cycle(1'b1, {6'h06, 4'd14, 4'd15, 18'h00007}, 1'b0);
      do_reset(1'b1);

`ifdef QTPA_DECODE_SCOREBOARD_EN
      // ADD_REG rd=5, then SUB_REG reading r5 stalls until writeback
      cycle(1'b1, {6'h11, 4'd5, 4'd1, 4'd2, 14'd0}, 1'b1);
      cycle(1'b1, {6'h12, 4'd6, 4'd1, 4'd5, 14'd0}, 1'b1);
      chk("sb_held_stall", obs_rdy, 1'b0);
      cycle(1'b1, {6'h12, 4'd6, 4'd1, 4'd5, 14'd0}, 1'b1);
      chk("sb_busy_stall", obs_rdy, 1'b0);
      cycle(1'b1, {6'h12, 4'd6, 4'd1, 4'd5, 14'd0}, 1'b1, 1'b0, 1'b1, 4'd5);
      chk("sb_wb_same_cycle", obs_rdy, 1'b0);
      cycle(1'b1, {6'h12, 4'd6, 4'd1, 4'd5, 14'd0}, 1'b1);
      chk("sb_released", obs_rdy, 1'b1);
      cycle(1'b0, 32'd0, 1'b1);
      // writeback of r5 coincides with issue of a new r5 writer: set wins
      cycle(1'b1, {6'h01, 4'd5, 4'd1, 18'd9}, 1'b1);
      cycle(1'b1, {6'h06, 4'd7, 4'd5, 18'd0}, 1'b1, 1'b0, 1'b1, 4'd5);
      chk("sb_setwin_a", obs_rdy, 1'b0);
      cycle(1'b1, {6'h06, 4'd7, 4'd5, 18'd0}, 1'b0);
      chk("sb_setwin_busy", obs_rdy, 1'b0);
      do_reset(1'b1);
      cycle(1'b1, {6'h06, 4'd7, 4'd5, 18'd0}, 1'b1);
      chk("sb_rst_clear", obs_rdy, 1'b1);
`endif

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset(1'b1);
         cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
               $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
               4'($urandom_range(0, 3)));
      end
      cycle(1'b0, 32'd0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
